// File: rtl/eq_output_serializer.sv
// Output end of the equalizer: rescales and saturates FIR results, buffers them,
// and streams them as a continuous left-justified two-slot serial frame to the DAC.
module eq_output_serializer #(
  parameter int SHIFT      = 15,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [43:0]                   i_result,
  input  logic                          i_valid,
  output logic                          o_sclk,
  output logic                          o_lrclk,
  output logic                          o_sdata,
  output logic                          o_sat,
  output logic                          o_overflow,
  output logic                          o_underflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  // state   | meaning
  // IDLE    | nothing sent yet; serial outputs held low until the first word arrives
  // RUN     | free-running frame generation; left only through reset

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]     DIV_TC  = DW'(CLK_DIV - 1);
  localparam logic signed [44:0] ROUND_C = 45'sd1 <<< (SHIFT - 1);
  localparam logic signed [44:0] SAT_MAX = 45'sd8388607;
  localparam logic signed [44:0] SAT_MIN = -45'sd8388608;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  logic              in_valid_q;
  logic [43:0]       in_result_q;
  logic signed [44:0] sum_s;
  logic signed [44:0] shr_s;
  logic [23:0]       s1_data_d;
  logic              s1_clip_d;
  logic              s1_valid_q;
  logic [23:0]       s1_data_q;
  logic              sat_q;

  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [LW-1:0]     level;
  logic              empty;
  logic              full;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic [23:0]       rd_data;
  logic              ovf_q;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [5:0]        bit_q, bit_d;
  logic [23:0]       word_q, word_d;
  logic              sdata_q, sdata_d;
  logic              lrclk_q, lrclk_d;
  logic              udf_q, udf_d;
  logic [5:0]        bit_n;
  logic [23:0]       next_word;
  logic [4:0]        pos;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      in_valid_q  <= 1'b0;
      in_result_q <= '0;
    end else begin
      in_valid_q <= i_valid;
      if (i_valid) in_result_q <= i_result;
    end
  end

  always_comb begin
    sum_s     = $signed({in_result_q[43], in_result_q}) + ROUND_C;
    shr_s     = sum_s >>> SHIFT;
    s1_clip_d = 1'b0;
    s1_data_d = shr_s[23:0];
    if (shr_s > SAT_MAX) begin
      s1_data_d = 24'h7FFFFF;
      s1_clip_d = 1'b1;
    end else if (shr_s < SAT_MIN) begin
      s1_data_d = 24'h800000;
      s1_clip_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_q;
      sat_q      <= in_valid_q & s1_clip_d;
      if (in_valid_q) s1_data_q <= s1_data_d;
    end
  end

  // A full FIFO still accepts a write when the serializer pops in the same cycle.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign push    = s1_valid_q;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= s1_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && !empty) state_d = ST_RUN;
  end

  always_comb begin
    pop       = 1'b0;
    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_d     = bit_q;
    word_d    = word_q;
    sdata_d   = sdata_q;
    lrclk_d   = lrclk_q;
    udf_d     = udf_q;
    bit_n     = bit_q + 6'd1;
    next_word = word_q;
    pos       = bit_n[4:0];
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          word_d  = rd_data;
          bit_d   = '0;
          sdata_d = rd_data[23];
          lrclk_d = 1'b0;
          div_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (div_q == DIV_TC) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Falling toggle: advance the slot position and present the next bit.
          if (sclk_q) begin
            if (bit_n == 6'd0) begin
              if (empty) begin
                next_word = '0;
                udf_d     = 1'b1;
              end else begin
                pop       = 1'b1;
                next_word = rd_data;
              end
            end
            bit_d   = bit_n;
            lrclk_d = bit_n[5];
            word_d  = next_word;
            sdata_d = (pos < 5'd24) ? next_word[5'd23 - pos] : 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q   <= '0;
      sclk_q  <= 1'b0;
      bit_q   <= '0;
      word_q  <= '0;
      sdata_q <= 1'b0;
      lrclk_q <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sdata_q <= sdata_d;
      lrclk_q <= lrclk_d;
      udf_q   <= udf_d;
    end
  end

  assign o_sclk      = sclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_sat       = sat_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
  assign o_level     = level;

endmodule

// File: tb/tb_eq_output_serializer.sv
// Bench for eq_output_serializer: rounding/saturation table, frame decoding via a
// serial monitor with a scoreboard queue, plus overflow and underflow sequences.
module tb_eq_output_serializer;

  localparam int SHIFT      = 15;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int NVEC       = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [43:0]   result = '0;
  logic          valid = 1'b0;
  logic          sclk, lrclk, sdata, sat, ovf, udf;
  logic [LW-1:0] level;

  eq_output_serializer #(.SHIFT(SHIFT), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_result(result), .i_valid(valid),
    .o_sclk(sclk), .o_lrclk(lrclk), .o_sdata(sdata), .o_sat(sat),
    .o_overflow(ovf), .o_underflow(udf), .o_level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [43:0] res;
    logic [23:0] word;
    logic        clip;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [23:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          mon_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] to_res(input logic [23:0] w);
    return {{5{w[23]}}, w, 15'b0};
  endfunction

  // Serial monitor: decodes slots on o_sclk rising edges, checks against the scoreboard.
  initial begin
    int          cyc;
    bit          seen_rise;
    logic        p_sclk, p_sdata, p_lr;
    logic [23:0] frame_exp;
    logic [31:0] slot_sr;
    cyc = 0; seen_rise = 0; p_sclk = 0; p_sdata = 0; p_lr = 0; frame_exp = '0; slot_sr = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mon_b = 0; cyc = 0; seen_rise = 0; p_sclk = 0; p_sdata = 0; p_lr = 0;
      end else begin
        cyc++;
        if (sdata !== p_sdata || lrclk !== p_lr) check("data_change_only_low_sclk", sclk, 1'b0);
        if (sclk && !p_sclk) begin
          if (seen_rise) check("sclk_period", cyc, 2 * CLK_DIV);
          cyc = 0; seen_rise = 1;
          if (mon_b == 0) frame_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 24'h0;
          check("lrclk_slot", lrclk, (mon_b >= 32));
          slot_sr = {slot_sr[30:0], sdata};
          if (mon_b == 31) check("left_slot", slot_sr, {frame_exp, 8'h00});
          if (mon_b == 63) check("right_slot", slot_sr, {frame_exp, 8'h00});
          mon_b = (mon_b + 1) % 64;
        end
        p_sclk = sclk; p_sdata = sdata; p_lr = lrclk;
      end
    end
  end

  task automatic wait_bit(input int target);
    int i;
    i = 0;
    while (mon_b != target && i < 1200) begin
      @(posedge clk); #1;
      i++;
    end
    check("wait_frame_position", mon_b, target);
  endtask

  // Called 1 time unit after an edge; leaves the bench at the same phase.
  task automatic drive_sample(input logic [43:0] r, input logic [23:0] w, input logic c);
    valid = 1'b1; result = r;
    sb_q.push_back(w);
    @(posedge clk); #1;
    valid = 1'b0;
    check("sat_before", sat, 1'b0);
    @(posedge clk); #1;
    check("sat_pulse", sat, c);
    @(posedge clk); #1;
    check("sat_after", sat, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{to_res(24'hA5A5A5), 24'hA5A5A5, 1'b0};
    vecs[1]  = '{44'sd114688, 24'h000004, 1'b0};
    vecs[2]  = '{-44'sd114688, 24'hFFFFFD, 1'b0};
    vecs[3]  = '{44'sd81919, 24'h000002, 1'b0};
    vecs[4]  = '{44'h7FFFFFFFFFF, 24'h7FFFFF, 1'b1};
    vecs[5]  = '{44'h80000000000, 24'h800000, 1'b1};
    vecs[6]  = '{-44'sd16384, 24'h000000, 1'b0};
    vecs[7]  = '{-44'sd16385, 24'hFFFFFF, 1'b0};
    vecs[8]  = '{44'h03FFFFFBFFF, 24'h7FFFFF, 1'b0};
    vecs[9]  = '{44'h03FFFFFC000, 24'h7FFFFF, 1'b1};
    vecs[10] = '{-44'sd274877923328, 24'h800000, 1'b0};
    vecs[11] = '{-44'sd274877923329, 24'h800000, 1'b1};

    // Reset held three cycles, then idle with no input.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", {sclk, lrclk, sdata, sat, ovf, udf, level}, '0);
    end

    // One vector per frame; each lands mid-frame and goes out in the next frame.
    drive_sample(vecs[0].res, vecs[0].word, vecs[0].clip);
    for (int k = 1; k < NVEC; k++) begin
      wait_bit(0);
      wait_bit(8);
      drive_sample(vecs[k].res, vecs[k].word, vecs[k].clip);
    end
    check("no_underflow_while_fed", udf, 1'b0);
    wait_bit(0); wait_bit(8);
    check("no_underflow_last_word", udf, 1'b0);
    wait_bit(0); wait_bit(8);
    check("underflow_set", udf, 1'b1);
    drive_sample(to_res(24'h123456), 24'h123456, 1'b0);
    wait_bit(0); wait_bit(8); wait_bit(0);
    check("underflow_sticky", udf, 1'b1);
    check("scoreboard_drained", sb_q.size(), 0);
    check("no_overflow_yet", ovf, 1'b0);

    // Mid-frame reset clears everything at once.
    wait_bit(20);
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    check("reset_midframe", {sclk, lrclk, sdata, sat, ovf, udf, level}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Six back-to-back results: one popped at RUN entry, four stored, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      logic [23:0] w;
      w = 24'h100001 * 24'(i + 1);
      valid = 1'b1; result = to_res(w);
      if (i < 5) sb_q.push_back(w);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    check("level_full", level, 4);
    check("overflow_not_yet", ovf, 1'b0);
    @(posedge clk); #1;
    check("level_after_drop", level, 4);
    check("overflow_set", ovf, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("overflow_sticky", ovf, 1'b1);
    for (int f = 0; f < 6; f++) begin
      wait_bit(8);
      wait_bit(0);
    end
    check("ovf_scoreboard_drained", sb_q.size(), 0);
    check("ovf_level_empty", level, 0);
    check("ovf_underflow_after_drain", udf, 1'b1);
    check("overflow_still_set", ovf, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
